// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: Moore state machine plus
// combinational ALU/immediate decoders driving the shared datapath selects.
module multicycle_controller #(
  parameter bit ENABLE_BNE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e     state_q;
  logic       pc_update;
  logic       branch;
  logic       taken;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:  state_q <= StDecode;
        StDecode: begin
          case (op)
            OpLoad, OpStore: state_q <= StMemAdr;
            OpRType:         state_q <= StExecuteR;
            OpIAlu:          state_q <= StExecuteI;
            OpBranch:        state_q <= StBeq;
            OpJal:           state_q <= StJal;
            default:         state_q <= StFetch;
          endcase
        end
        StMemAdr:   state_q <= (op == OpStore) ? StMemWrite : StMemRead;
        StMemRead:  state_q <= StMemWb;
        StMemWb:    state_q <= StFetch;
        StMemWrite: state_q <= StFetch;
        StExecuteR: state_q <= StAluWb;
        StExecuteI: state_q <= StAluWb;
        StAluWb:    state_q <= StFetch;
        StBeq:      state_q <= StFetch;
        StJal:      state_q <= StAluWb;
        default:    state_q <= StFetch;
      endcase
    end
  end

  assign state = state_q;

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch outcome is evaluated combinationally from the live Zero flag in BEQ.
  always_comb begin
    taken = 1'b0;
    if (funct3 == 3'b000) begin
      taken = Zero;
    end else if (ENABLE_BNE && (funct3 == 3'b001)) begin
      taken = !Zero;
    end
  end

  assign PCWrite = pc_update | (branch & taken);

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I processor that succeeds the single-cycle core. It sequences one shared ALU, one unified instruction/data memory and the register file over 3–5 cycles per instruction, using a Moore FSM plus combinational ALU and immediate decoders. It sits in the controller half of the core, driving datapath select lines from the opcode, funct3, funct7[5] and the ALU Zero flag.

Parameters:
ENABLE_BNE, 0, when 1 a branch opcode with funct3=001 (bne) is taken on !Zero; when 0 only beq (funct3=000) is decoded and all other branch funct3 values are treated as not taken.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  7  instr[6:0], sampled from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU result == 0
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register (and OldPC) enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 (A)
ALUSrcB  output  2  00=rs2 (WriteData), 01=ImmExt, 10=constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
RegWrite  output  1  register file write enable
state  output  4  current state, for debug and bench observation

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, and forces state=FETCH(0) immediately. While reset is held, outputs equal the FETCH decode: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUControl=000, and PCWrite=1. The datapath holds its own registers in reset, so these values are harmless.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are illegal and return to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for op 0000011 (lw) or 0100011 (sw).
  - DECODE→EXECUTER for 0110011.
  - DECODE→EXECUTEI for 0010011.
  - DECODE→BEQ for 1100011.
  - DECODE→JAL for 1101111.
  - DECODE→FETCH for any other op (executes as a nop; no writes occur).
  - MEMADR→MEMREAD for lw, →MEMWRITE for sw.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
- Moore outputs per state. Any select not listed is 00; any enable not listed is 0.
  - FETCH: IRWrite, PCUpdate, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Computes the branch target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: AdrSrc=1, MemWrite.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite, ResultSrc=00.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate.
- PCWrite = PCUpdate | (Branch & taken), combinational.
  - taken = Zero when funct3=000.
  - taken = !Zero when funct3=001 and ENABLE_BNE=1.
  - taken = 0 otherwise.
- ALU decoder (combinational):
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if (op[5] & funct7b5), else add. addi with instr[30]=1 remains add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - any other → add.
- ImmSrc (combinational from op, valid in every state): lw/I-ALU 00, sw 01, branch 10, jal 11, anything else 00.
- Latency in cycles including FETCH: lw 5, sw 4, R 4, I-ALU 4, branch 3, jal 4, unknown 2.
- Reset mid-instruction: the state is abandoned without completing. A MemWrite or RegWrite pending in the next state never asserts.

Test Plan:
- Reset and fetch: assert reset for 22 ns (clock period 10) → state=0 throughout and IRWrite=1. After release: state sequence 0→1→… and PCWrite=1 in FETCH only.
- lw (op=0000011): state 0,1,2,3,4,0 → AdrSrc=1 in MEMREAD; RegWrite=1 with ResultSrc=01 only in MEMWB; MemWrite stays 0.
- sw (op=0100011) → states 0,1,2,5,0. MemWrite=1 for exactly one cycle in state 5 with AdrSrc=1; ImmSrc=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in state 6. and/or/slt funct3 give 010/011/101. addi with instr[30]=1 gives 000.
- beq (op=1100011):
  - Zero=1 → PCWrite=1 in state 9.
  - Zero=0 → PCWrite=0.
  - With ENABLE_BNE=1 and funct3=001, the behaviour inverts.
- jal (op=1101111) → states 0,1,10,8,0, with PCWrite=1 in 10 and RegWrite=1 in 8. Reset asserted during state 8 → state=0 asynchronously and RegWrite=0 with no clock edge.
